// File: rtl/wb_stage.sv
// Writeback stage: registers MEM/WB payload and drives the register file write port from it; outputs one cycle after capture.
// stall holds the WB register and suppresses write/retire; flush kills the incoming instruction.
module wb_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                stall,
    input  logic                flush,
    input  logic [4:0]          in_rd,
    input  logic                in_reg_write,
    input  logic [1:0]          in_wb_sel,
    input  logic [31:0]         in_alu_result,
    input  logic [31:0]         in_mem_rdata,
    input  logic [2:0]          in_load_funct3,
    input  logic [31:0]         in_pc_plus4,
    output logic [4:0]          write_reg,
    output logic signed [31:0]  write_data,
    output logic                write_en,
    output logic                wb_valid,
    output logic [RETIRE_W-1:0] retired_count
);

    typedef struct packed {
        logic        vld;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [2:0]  funct3;
        logic [31:0] pc4;
    } wb_pl_t;

    wb_pl_t              pl_q, pl_d;
    logic [RETIRE_W-1:0] cnt_q, cnt_d;
    logic                retire;
    logic [1:0]          off;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_val;
    logic [31:0]         result;

    always_comb begin
        pl_d = pl_q;
        if (!stall) begin
            if (flush) begin
                pl_d.vld = 1'b0;
            end else begin
                pl_d.vld       = in_valid;
                pl_d.rd        = in_rd;
                pl_d.reg_write = in_reg_write;
                pl_d.wb_sel    = in_wb_sel;
                pl_d.alu       = in_alu_result;
                pl_d.rdata     = in_mem_rdata;
                pl_d.funct3    = in_load_funct3;
                pl_d.pc4       = in_pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pl_q <= '0;
        end else begin
            pl_q <= pl_d;
        end
    end

    assign retire = pl_q.vld & ~stall;
    assign cnt_d  = retire ? cnt_q + RETIRE_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Little-endian lane select; halfwords ignore off[0] (misaligned lh is not split).
    always_comb begin
        off      = pl_q.alu[1:0];
        byte_sel = pl_q.rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? pl_q.rdata[31:16] : pl_q.rdata[15:0];
        case (pl_q.funct3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = pl_q.rdata;
        endcase
    end

    always_comb begin
        case (pl_q.wb_sel)
            2'b01:   result = load_val;
            2'b10:   result = pl_q.pc4;
            default: result = pl_q.alu;
        endcase
    end

    assign write_data    = $signed(result);
    assign write_reg     = pl_q.rd;
    assign write_en      = retire & pl_q.reg_write & (pl_q.rd != 5'd0);
    assign wb_valid      = pl_q.vld;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases then random traffic against a behavioural model; a RETIRE_W=4 copy checks counter wrap.
module tb_wb_stage;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, stall, flush, in_reg_write;
    logic [4:0]         in_rd;
    logic [1:0]         in_wb_sel;
    logic [31:0]        in_alu_result, in_mem_rdata, in_pc_plus4;
    logic [2:0]         in_load_funct3;
    logic [4:0]         write_reg, write_reg4;
    logic signed [31:0] write_data, write_data4;
    logic               write_en, wb_valid, write_en4, wb_valid4;
    logic [31:0]        retired_count;
    logic [3:0]         retired_count4;

    int errors = 0;
    int checks = 0;

    // reference model state: the captured instruction and a retirement tally
    logic        m_vld, m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_rdata, m_pc4, m_cnt;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_load_funct3(in_load_funct3), .in_pc_plus4(in_pc_plus4),
        .write_reg(write_reg), .write_data(write_data), .write_en(write_en),
        .wb_valid(wb_valid), .retired_count(retired_count)
    );

    wb_stage #(.RETIRE_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_load_funct3(in_load_funct3), .in_pc_plus4(in_pc_plus4),
        .write_reg(write_reg4), .write_data(write_data4), .write_en(write_en4),
        .wb_valid(wb_valid4), .retired_count(retired_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int unsigned o = addr % 4;
        int unsigned b = (word >> (8 * o)) % 256;
        int unsigned h = (word >> (16 * (o / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_data();
        if (m_sel == 2'd1) return ref_load(m_rdata, m_alu, m_f3);
        if (m_sel == 2'd2) return m_pc4;
        return m_alu;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
        m_alu = 0; m_rdata = 0; m_pc4 = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(m_vld));
        chk({tag, ".write_en"}, 32'(write_en), 32'(m_vld && !stall && m_rw && m_rd != 0));
        chk({tag, ".write_reg"}, 32'(write_reg), 32'(m_rd));
        chk({tag, ".write_data"}, write_data, ref_data());
        chk({tag, ".retired"}, retired_count, m_cnt);
        chk({tag, ".retired4"}, 32'(retired_count4), m_cnt % 16);
    endtask

    // check outputs for the current cycle, cross the edge, mirror it in the model
    task automatic tick(input string tag);
        #1 check_all(tag);
        @(posedge clk);
        if (m_vld && !stall) m_cnt = m_cnt + 1;
        if (!stall) begin
            if (flush) m_vld = 0;
            else begin
                m_vld = in_valid; m_rd = in_rd; m_rw = in_reg_write; m_sel = in_wb_sel;
                m_alu = in_alu_result; m_rdata = in_mem_rdata; m_f3 = in_load_funct3;
                m_pc4 = in_pc_plus4;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [2:0] f3,
                         input logic [31:0] pc4);
        in_valid = v; in_rd = rd; in_reg_write = rw; in_wb_sel = sel;
        in_alu_result = alu; in_mem_rdata = rdata; in_load_funct3 = f3; in_pc_plus4 = pc4;
    endtask

    task automatic bubble();
        drive(0, 5'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom), $urandom);
    endtask

    logic [2:0]  ld_f3  [6] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd5, 3'd2};
    logic [1:0]  ld_off [6] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
    logic [31:0] ld_exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                                32'hFFFF_80F0, 32'h0000_7F01, 32'h80F0_7F01};

    initial begin
        logic [31:0] base;
        rst = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        check_all("reset");
        chk("reset.write_data", write_data, 32'd0);
        rst = 0;

        // ALU writeback
        drive(1, 5'd10, 1, 2'b00, 32'd12983, $urandom, 3'($urandom), $urandom);
        tick("alu_cap");
        bubble();
        #1;
        chk("alu.write_en", 32'(write_en), 32'd1);
        chk("alu.write_reg", 32'(write_reg), 32'd10);
        chk("alu.write_data", write_data, 32'd12983);
        chk("alu.count_before", retired_count, 32'd0);
        tick("alu_wb");
        chk("alu.count_after", retired_count, 32'd1);

        // load extraction table
        for (int i = 0; i < 6; i++) begin
            base = $urandom;
            drive(1, 5'd5, 1, 2'b01, {base[31:2], ld_off[i]}, 32'h80F0_7F01, ld_f3[i], $urandom);
            tick("load_cap");
            #1 chk($sformatf("load%0d.data", i), write_data, ld_exp[i]);
        end

        // x0 destination and a non-writing store both retire without writing
        drive(1, 5'd0, 1, 2'b00, 32'd500, 0, 0, 0);
        tick("x0_cap");
        drive(1, 5'd7, 0, 2'b00, $urandom, 0, 0, 0);
        #1 chk("x0.write_en", 32'(write_en), 32'd0);
        tick("x0_wb");
        drive(1, 5'd1, 1, 2'b10, $urandom, $urandom, 3'd0, 32'h0000_0104);
        #1 chk("store.write_en", 32'(write_en), 32'd0);
        tick("store_wb");
        bubble();
        #1 chk("link.write_data", write_data, 32'h104);
        tick("link_wb");

        // stall for three cycles, then exactly one write
        drive(1, 5'd3, 1, 2'b00, 32'hDEAD_BEEF, 0, 0, 0);
        tick("stall_cap");
        stall = 1;
        base = retired_count;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'($urandom), 1, 2'b00, $urandom, 0, 0, 0);
            #1 chk("stall.write_en", 32'(write_en), 32'd0);
            tick("stall_hold");
            chk("stall.count", retired_count, base);
        end
        stall = 0;
        bubble();
        #1 chk("unstall.write_en", 32'(write_en), 32'd1);
        chk("unstall.write_data", write_data, 32'hDEAD_BEEF);
        tick("unstall");
        chk("unstall.count", retired_count, base + 1);
        #1 chk("unstall.once", 32'(write_en), 32'd0);

        // flush kills the incoming instruction
        flush = 1;
        drive(1, 5'd9, 1, 2'b00, 32'd77, 0, 0, 0);
        tick("flush");
        flush = 0;
        bubble();
        #1 chk("flush.wb_valid", 32'(wb_valid), 32'd0);
        tick("flush_after");

        // stall beats flush
        drive(1, 5'd12, 1, 2'b00, 32'd4242, 0, 0, 0);
        tick("sf_cap");
        stall = 1; flush = 1;
        drive(1, 5'd13, 1, 2'b00, 32'd1, 0, 0, 0);
        tick("sf_both");
        stall = 0; flush = 0;
        bubble();
        #1;
        chk("sf.wb_valid", 32'(wb_valid), 32'd1);
        chk("sf.write_reg", 32'(write_reg), 32'd12);
        chk("sf.write_en", 32'(write_en), 32'd1);
        tick("sf_wb");

        // reset between edges while a write is live
        drive(1, 5'd20, 1, 2'b00, 32'h1234_5678, 0, 0, 0);
        tick("rst_cap");
        #1 chk("prerst.write_en", 32'(write_en), 32'd1);
        rst = 1;
        model_reset();
        #1;
        chk("rst.write_en", 32'(write_en), 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.write_reg", 32'(write_reg), 32'd0);
        chk("rst.write_data", write_data, 32'd0);
        chk("rst.count", retired_count, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;

        // 17 retirements wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drive(1, 5'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom), $urandom);
            tick("wrap");
        end
        bubble();
        tick("wrap_drain");
        chk("wrap.count4", 32'(retired_count4), 32'd1);
        chk("wrap.count32", retired_count, 32'd17);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 7) == 0;
            drive(($urandom % 5) != 0, (($urandom % 8) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom), 2'($urandom), $urandom, $urandom, 3'($urandom), $urandom);
            tick("rand");
        end
        stall = 0; flush = 0;
        bubble();
        tick("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
